imm_encoder: RTL and testbench
==============================

IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 clk  input  1  single clock; all state on rising edge.
REQ-002 rst_n  input  1  reset, asynchronous, active-low.
REQ-003 in_valid  input  1  request present on in_* fields.
REQ-004 in_ready  output  1  encoder accepts the request this cycle.
REQ-005 in_fmt  input  3  format: 0 R, 1 I, 2 S, 3 B, 4 U, 5 J; 6-7 illegal.
REQ-006 in_opcode  input  7  opcode placed in bits [6:0].
REQ-007 in_rd, in_rs1, in_rs2  input  5 each  register fields.
REQ-008 in_funct3  input  3; in_funct7  input  7  function fields.
REQ-009 in_imm  input  32  signed immediate, byte offset for B/J, full value for U.
REQ-010 out_valid  output  1  encoded word available at buffer head.
REQ-011 out_ready  input  1  consumer takes the head word.
REQ-012 out_instr  output  32  encoded instruction word.
REQ-013 out_err  output  1  head word failed a range, alignment or format check.
REQ-014 err_cnt  output  8  saturating count of accepted requests flagged in error.

Function
REQ-015 Transfer: input accepted when in_valid & in_ready; output consumed when out_valid & out_ready.
REQ-016 Buffer: 2-entry FIFO of {out_instr, out_err}. in_ready = (count < 2), registered or derived from state only, never from in_valid.
REQ-017 Latency: accepted request appears on out_* on the next rising edge when the FIFO is empty. Otherwise it appears after all older entries drain; order is preserved.
REQ-018 Simultaneous push and pop: count is unchanged and the head advances. At count 2 no push can occur. At count 0, pop cannot occur because out_valid is 0.
REQ-019 out_instr and out_err hold stable while out_valid & !out_ready.
REQ-020 Common fields: [6:0] opcode. [11:7] rd for R/I/U/J. [14:12] funct3 for R/I/S/B. [19:15] rs1 for R/I/S/B. [24:20] rs2 for R/S/B.
REQ-021 R: [31:25] funct7; in_imm ignored; never errors.
REQ-022 I: [31:20] imm[11:0]. Error if imm outside -2048..2047.
REQ-023 S: [31:25] imm[11:5], [11:7] imm[4:0]. Error if imm outside -2048..2047.
REQ-024 B: [31] imm[12], [30:25] imm[10:5], [11:8] imm[4:1], [7] imm[11]. Error if imm outside -4096..4094 or imm[0]=1.
REQ-025 U: [31:12] imm[31:12]. Error if imm[11:0] != 0.
REQ-026 J: [31] imm[20], [30:21] imm[10:1], [20] imm[11], [19:12] imm[19:12]. Error if imm outside -1048576..1048574 or imm[0]=1.
REQ-027 Errored words are still encoded from the truncated bits and emitted with out_err=1.
REQ-028 Illegal fmt (6, 7): out_instr = 32'h0000_0000, out_err=1.
REQ-029 err_cnt increments by 1 on each accepted errored request, evaluated at accept, and saturates at 255.

Reset
REQ-030 On rst_n low, immediately and independently of clk: FIFO count=0, pointers=0, out_valid=0, out_err=0, out_instr=0, err_cnt=0, in_ready=1.
REQ-031 Reset mid-operation discards all buffered words; no partial word is emitted after release.
REQ-032 First accept is possible on the first rising edge with rst_n high.

Verification
REQ-033 I-format, fmt=1, opcode=7'h13, rd=1, rs1=0, funct3=0, imm=5, out_ready=1 -> next cycle out_instr=32'h0050_0093, out_err=0.
REQ-034 B-format, fmt=3, opcode=7'h63, rs1=1, rs2=2, funct3=0, imm=-4 -> out_instr=32'hFE20_8EE3, out_err=0. Same request with imm=3 -> out_err=1, err_cnt=1.
REQ-035 out_ready=0 with three back-to-back requests -> two accepted, in_ready=0 from the cycle after the second accept. The third request is held until out_ready=1, then all three words emerge in order.
REQ-036 FIFO count=1 with simultaneous push and pop for 10 cycles -> out_valid stays 1, in_ready stays 1, words emerge in order with 1-cycle spacing.
REQ-037 260 errored requests (fmt=7) -> err_cnt=255 and no wrap. Then assert rst_n=0 mid-stream with count=2 -> all outputs 0 and in_ready=1 without a clock edge.

Source files
------------

// File: rtl/imm_encoder_if.sv
// Request/response bundle for the RISC-V immediate encoder.
// Requests enter on in_*; encoded words leave on out_*.
interface imm_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_fmt;
  logic [6:0]  in_opcode;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic [6:0]  in_funct7;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic        out_err;

  modport master (
    output in_valid,
    output in_fmt,
    output in_opcode,
    output in_rd,
    output in_rs1,
    output in_rs2,
    output in_funct3,
    output in_funct7,
    output in_imm,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_instr,
    input  out_err
  );

  modport slave (
    input  in_valid,
    input  in_fmt,
    input  in_opcode,
    input  in_rd,
    input  in_rs1,
    input  in_rs2,
    input  in_funct3,
    input  in_funct7,
    input  in_imm,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_instr,
    output out_err
  );
endinterface

// File: rtl/imm_encoder.sv
// RISC-V instruction word encoder with range/alignment checks
// and a 2-entry output FIFO; counts errored requests.
module imm_encoder (
  input  logic       clk,
  input  logic       rst_n,
  imm_encoder_if.slave bus,
  output logic [7:0] err_cnt
);

  typedef enum logic [2:0] {
    F_R = 3'd0,
    F_I = 3'd1,
    F_S = 3'd2,
    F_B = 3'd3,
    F_U = 3'd4,
    F_J = 3'd5
  } fmt_e;

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } entry_t;

  logic [2:0]  fmt;
  logic [6:0]  opc;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm;

  assign fmt = bus.in_fmt;
  assign opc = bus.in_opcode;
  assign rd  = bus.in_rd;
  assign rs1 = bus.in_rs1;
  assign rs2 = bus.in_rs2;
  assign f3  = bus.in_funct3;
  assign f7  = bus.in_funct7;
  assign imm = bus.in_imm;

  // Odd upper bounds are rejected separately by the imm[0] check.
  logic fits12;
  logic fits13;
  logic fits21;

  assign fits12 = ($signed(imm) >= -32'sd2048) &&
                  ($signed(imm) <=  32'sd2047);
  assign fits13 = ($signed(imm) >= -32'sd4096) &&
                  ($signed(imm) <=  32'sd4095);
  assign fits21 = ($signed(imm) >= -32'sd1048576) &&
                  ($signed(imm) <=  32'sd1048575);

  entry_t enc;

  always_comb begin
    enc = '0;
    unique case (1'b1)
      fmt == F_R: begin
        enc.instr = {f7, rs2, rs1, f3, rd, opc};
      end
      fmt == F_I: begin
        enc.instr = {imm[11:0], rs1, f3, rd, opc};
        enc.err   = !fits12;
      end
      fmt == F_S: begin
        enc.instr = {imm[11:5], rs2, rs1, f3,
                     imm[4:0], opc};
        enc.err   = !fits12;
      end
      fmt == F_B: begin
        enc.instr = {imm[12], imm[10:5], rs2, rs1,
                     f3, imm[4:1], imm[11], opc};
        enc.err   = !fits13 || imm[0];
      end
      fmt == F_U: begin
        enc.instr = {imm[31:12], rd, opc};
        enc.err   = |imm[11:0];
      end
      fmt == F_J: begin
        enc.instr = {imm[20], imm[10:1], imm[11],
                     imm[19:12], rd, opc};
        enc.err   = !fits21 || imm[0];
      end
      default: begin
        enc.instr = '0;
        enc.err   = 1'b1;
      end
    endcase
  end

  entry_t     mem [2];
  logic [1:0] count;
  logic       wr_ptr;
  logic       rd_ptr;
  logic       push;
  logic       pop;

  assign bus.in_ready  = (count != 2'd2);
  assign bus.out_valid = (count != 2'd0);
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  // Gate with valid so an empty FIFO always presents zeros.
  assign bus.out_instr = bus.out_valid ?
                         mem[rd_ptr].instr : 32'h0;
  assign bus.out_err   = bus.out_valid &&
                         mem[rd_ptr].err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= enc;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= 8'd0;
    end else if (push && enc.err &&
                 err_cnt != 8'hFF) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: reference encoder,
// FIFO back-pressure, saturation and async reset.
module tb_imm_encoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] err_cnt;

  imm_encoder_if bus ();

  imm_encoder dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .err_cnt (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  opc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } req_t;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [32:0] sb [$];
  req_t        cur;
  bit          accepted;
  int          exp_cnt = 0;
  req_t        tbl [$];

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model(req_t r);
    logic [31:0] w;
    logic        e;
    longint      s;
    s = longint'($signed(r.imm));
    w = 32'h0;
    e = 1'b0;
    w[6:0] = r.opc;
    case (r.fmt)
      3'd0: begin
        w[11:7] = r.rd; w[14:12] = r.f3;
        w[19:15] = r.rs1; w[24:20] = r.rs2;
        w[31:25] = r.f7;
      end
      3'd1: begin
        w[11:7] = r.rd; w[14:12] = r.f3;
        w[19:15] = r.rs1; w[31:20] = r.imm[11:0];
        e = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w[11:7] = r.imm[4:0]; w[14:12] = r.f3;
        w[19:15] = r.rs1; w[24:20] = r.rs2;
        w[31:25] = r.imm[11:5];
        e = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w[7] = r.imm[11]; w[11:8] = r.imm[4:1];
        w[14:12] = r.f3; w[19:15] = r.rs1;
        w[24:20] = r.rs2; w[30:25] = r.imm[10:5];
        w[31] = r.imm[12];
        e = (s < -4096) || (s > 4094) || r.imm[0];
      end
      3'd4: begin
        w[11:7] = r.rd; w[31:12] = r.imm[31:12];
        e = (r.imm[11:0] != 12'h0);
      end
      3'd5: begin
        w[11:7] = r.rd; w[19:12] = r.imm[19:12];
        w[20] = r.imm[11]; w[30:21] = r.imm[10:1];
        w[31] = r.imm[20];
        e = (s < -1048576) || (s > 1048574) ||
            r.imm[0];
      end
      default: begin
        w = 32'h0;
        e = 1'b1;
      end
    endcase
    return {e, w};
  endfunction

  function automatic req_t mk(input logic [2:0] f,
                              input logic [31:0] imm);
    req_t r;
    r.fmt = f;
    r.opc = 7'($urandom);
    r.rd  = 5'($urandom);
    r.rs1 = 5'($urandom);
    r.rs2 = 5'($urandom);
    r.f3  = 3'($urandom);
    r.f7  = 7'($urandom);
    r.imm = imm;
    return r;
  endfunction

  task automatic drive(input req_t r);
    cur = r;
    bus.in_fmt    = r.fmt;
    bus.in_opcode = r.opc;
    bus.in_rd     = r.rd;
    bus.in_rs1    = r.rs1;
    bus.in_rs2    = r.rs2;
    bus.in_funct3 = r.f3;
    bus.in_funct7 = r.f7;
    bus.in_imm    = r.imm;
    bus.in_valid  = 1'b1;
  endtask

  // Sample at negedge, then advance to just past posedge.
  task automatic step();
    logic [32:0] m;
    @(negedge clk);
    if (bus.out_valid) begin
      if (sb.size() == 0) begin
        chk("sb_underflow", 64'(bus.out_valid), 0);
      end else begin
        chk("out_word", {bus.out_err, bus.out_instr},
            sb[0]);
        if (bus.out_ready) void'(sb.pop_front());
      end
    end
    accepted = 1'b0;
    if (bus.in_valid && bus.in_ready) begin
      m = model(cur);
      sb.push_back(m);
      if (m[32] && exp_cnt != 255) exp_cnt++;
      accepted = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input req_t r);
    drive(r);
    for (int i = 0; i < 20; i++) begin
      step();
      if (accepted) break;
    end
    chk("send_accept", 64'(accepted), 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 50 && sb.size() != 0; i++)
      step();
    chk("drain_empty", sb.size(), 0);
    chk("err_cnt", err_cnt, exp_cnt);
  endtask

  req_t r;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_fmt    = 3'd0;
    bus.in_opcode = 7'd0;
    bus.in_rd     = 5'd0;
    bus.in_rs1    = 5'd0;
    bus.in_rs2    = 5'd0;
    bus.in_funct3 = 3'd0;
    bus.in_funct7 = 7'd0;
    bus.in_imm    = 32'd0;
    bus.out_ready = 1'b1;
    #12;
    chk("rst_valid", 64'(bus.out_valid), 0);
    chk("rst_ready", 64'(bus.in_ready), 1);
    chk("rst_instr", bus.out_instr, 0);
    chk("rst_err", 64'(bus.out_err), 0);
    chk("rst_cnt", err_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    r = '{3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0,
          7'd0, 32'd5};
    send(r);
    chk("i_valid", 64'(bus.out_valid), 1);
    chk("i_instr", bus.out_instr, 32'h0050_0093);
    chk("i_err", 64'(bus.out_err), 0);

    r = '{3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0,
          7'd0, 32'hFFFF_FFFC};
    send(r);
    chk("b_instr", bus.out_instr, 32'hFE20_8EE3);
    chk("b_err", 64'(bus.out_err), 0);
    r.imm = 32'd3;
    send(r);
    chk("b_odd_err", 64'(bus.out_err), 1);
    chk("b_odd_cnt", err_cnt, 1);
    drain();

    tbl.push_back(mk(3'd0, 32'hDEAD_BEEF));
    tbl.push_back(mk(3'd1, 32'(2047)));
    tbl.push_back(mk(3'd1, 32'(2048)));
    tbl.push_back(mk(3'd1, 32'(-2048)));
    tbl.push_back(mk(3'd1, 32'(-2049)));
    tbl.push_back(mk(3'd2, 32'(2047)));
    tbl.push_back(mk(3'd2, 32'(-2049)));
    tbl.push_back(mk(3'd2, 32'(-37)));
    tbl.push_back(mk(3'd3, 32'(4094)));
    tbl.push_back(mk(3'd3, 32'(4096)));
    tbl.push_back(mk(3'd3, 32'(-4096)));
    tbl.push_back(mk(3'd3, 32'(-4098)));
    tbl.push_back(mk(3'd3, 32'(4095)));
    tbl.push_back(mk(3'd4, 32'h1234_5000));
    tbl.push_back(mk(3'd4, 32'h1234_5001));
    tbl.push_back(mk(3'd5, 32'(1048574)));
    tbl.push_back(mk(3'd5, 32'(1048576)));
    tbl.push_back(mk(3'd5, 32'(-1048576)));
    tbl.push_back(mk(3'd5, 32'(-1048578)));
    tbl.push_back(mk(3'd5, 32'(2001)));
    tbl.push_back(mk(3'd6, 32'd0));
    foreach (tbl[i]) send(tbl[i]);
    drain();

    bus.out_ready = 1'b0;
    drive(mk(3'd1, 32'(100)));
    step();
    chk("bp_acc1", 64'(accepted), 1);
    drive(mk(3'd2, 32'(-100)));
    step();
    chk("bp_acc2", 64'(accepted), 1);
    chk("bp_full", 64'(bus.in_ready), 0);
    drive(mk(3'd5, 32'(64)));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold", 64'(accepted), 0);
    end
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (accepted) break;
    end
    chk("bp_acc3", 64'(accepted), 1);
    drain();

    bus.out_ready = 1'b0;
    send(mk(3'd0, 32'd0));
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(mk(3'(i % 6), 32'(i * 8)));
      step();
      chk("pp_acc", 64'(accepted), 1);
      chk("pp_valid", 64'(bus.out_valid), 1);
      chk("pp_ready", 64'(bus.in_ready), 1);
    end
    drain();

    for (int i = 0; i < 260; i++) begin
      drive(mk(3'd7, 32'(i)));
      step();
    end
    drain();
    chk("sat_cnt", err_cnt, 255);

    bus.out_ready = 1'b0;
    send(mk(3'd1, 32'd1));
    send(mk(3'd1, 32'd2));
    chk("pre_rst_full", 64'(bus.in_ready), 0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.out_valid), 0);
    chk("arst_instr", bus.out_instr, 0);
    chk("arst_err", 64'(bus.out_err), 0);
    chk("arst_cnt", err_cnt, 0);
    chk("arst_ready", 64'(bus.in_ready), 1);
    sb.delete();
    exp_cnt = 0;
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive(mk(3'd4, 32'hABCD_E000));
    step();
    chk("post_rst_acc", 64'(accepted), 1);
    drain();

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
